// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the ID/EXE issue logic.
//   ALU control codes, primary opcodes, R-type funct codes, default
//   datapath width, and the decoded-control bundle.
package cpu_pkg;

   localparam int DATA_W = 32;
   localparam int IMM_W  = 16;

   localparam logic [3:0] ALUC_AND = 4'b0000;
   localparam logic [3:0] ALUC_OR  = 4'b0001;
   localparam logic [3:0] ALUC_ADD = 4'b0010;
   localparam logic [3:0] ALUC_SUB = 4'b0110;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;

   typedef struct packed {
      logic [3:0] aluc;
      logic       aluimm;
      logic       sext;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational ALU-control decoder.
//   op, funct  : instruction opcode / R-type function fields
//   aluc       : 4-bit ALU control code
//   aluimm     : operand B comes from the extended immediate
//   sext       : immediate is sign-extended (else zero-extended)
//   illegal    : instruction is not supported
module alu_ctrl_decode
   import cpu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [3:0] aluc,
   output logic       aluimm,
   output logic       sext,
   output logic       illegal
);

   dec_t d;

   always_comb begin
      // Illegal encodings decode to AND with no immediate; the top level
      // turns them into a bubble, so these values never reach the ALU.
      d = '{aluc: ALUC_AND, aluimm: 1'b0, sext: 1'b0, illegal: 1'b0};
      unique case (op)
         OP_RTYPE: begin
            unique case (funct)
               F_ADD:   d.aluc = ALUC_ADD;
               F_SUB:   d.aluc = ALUC_SUB;
               F_AND:   d.aluc = ALUC_AND;
               F_OR:    d.aluc = ALUC_OR;
               default: d.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: d = '{aluc: ALUC_ADD, aluimm: 1'b1, sext: 1'b1, illegal: 1'b0};
         OP_ANDI: d = '{aluc: ALUC_AND, aluimm: 1'b1, sext: 1'b0, illegal: 1'b0};
         OP_ORI:  d = '{aluc: ALUC_OR,  aluimm: 1'b1, sext: 1'b0, illegal: 1'b0};
         OP_BEQ:  d.aluc = ALUC_SUB;
         default: d.illegal = 1'b1;
      endcase
   end

   assign aluc    = d.aluc;
   assign aluimm  = d.aluimm;
   assign sext    = d.sext;
   assign illegal = d.illegal;

endmodule

// File: rtl/id_exe_alu_issue.sv
// id_exe_alu_issue: ID->EXE issue stage feeding the EXE ALU.
//   clk, rst          : clock, async active-high reset
//   stall, flush      : hold / bubble the ID/EXE register (flush wins)
//   d_valid, d_inst   : ID-stage instruction
//   d_qa, d_qb        : forwarded rs / rt values
//   e_valid, ealuc    : EXE entry valid, ALU control
//   eqa, b            : ALU operands A and B
//   e_qb              : registered rt (store data / branch compare)
//   e_aluimm          : b was taken from the immediate
//   e_illegal         : one-cycle flag for a dropped illegal instruction
// All outputs come straight from flops: one cycle latency, no comb path.
module id_exe_alu_issue
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int IMM_W  = cpu_pkg::IMM_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              d_valid,
   input  logic [31:0]       d_inst,
   input  logic [DATA_W-1:0] d_qa,
   input  logic [DATA_W-1:0] d_qb,
   output logic              e_valid,
   output logic [3:0]        ealuc,
   output logic [DATA_W-1:0] eqa,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] e_qb,
   output logic              e_aluimm,
   output logic              e_illegal
);

   logic [3:0]        aluc;
   logic              aluimm, sext, illegal;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] imm_ext, b_sel;

   alu_ctrl_decode u_dec (
      .op      (d_inst[31:26]),
      .funct   (d_inst[5:0]),
      .aluc    (aluc),
      .aluimm  (aluimm),
      .sext    (sext),
      .illegal (illegal)
   );

   // Register-number fields are consumed elsewhere in the pipeline.
   logic unused_fields;
   assign unused_fields = ^d_inst[25:IMM_W];

   assign imm     = d_inst[IMM_W-1:0];
   assign imm_ext = sext ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                         : {{(DATA_W-IMM_W){1'b0}}, imm};
   assign b_sel   = aluimm ? imm_ext : d_qb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         // rst arrives asynchronously; flush is only seen at the edge.
         e_valid   <= 1'b0;
         ealuc     <= ALUC_AND;
         eqa       <= '0;
         b         <= '0;
         e_qb      <= '0;
         e_aluimm  <= 1'b0;
         e_illegal <= 1'b0;
      end else if (!stall) begin
         if (d_valid && !illegal) begin
            e_valid   <= 1'b1;
            ealuc     <= aluc;
            eqa       <= d_qa;
            b         <= b_sel;
            e_qb      <= d_qb;
            e_aluimm  <= aluimm;
            e_illegal <= 1'b0;
         end else begin
            // Bubble; remember for one cycle that an illegal op was dropped.
            e_valid   <= 1'b0;
            ealuc     <= ALUC_AND;
            eqa       <= '0;
            b         <= '0;
            e_qb      <= '0;
            e_aluimm  <= 1'b0;
            e_illegal <= d_valid & illegal;
         end
      end
   end

endmodule

// File: doc/id_exe_alu_issue.md
Name: id_exe_alu_issue

Overview:
- ID→EXE issue stage of the 5-stage CPU pipeline, upstream of the EXE-stage ALU.
- Decodes the ID-stage instruction into the 4-bit ALU control code and selects operand B (register value or extended immediate).
- Registers both into the ID/EXE pipeline register, so ealuc, eqa and b arrive at the ALU one cycle later.
- Handles stall (hold), flush (bubble) and illegal-opcode detection.

Parameters:
- DATA_W, 32, datapath width of operands.
- IMM_W, 16, instruction immediate field width; extended to DATA_W.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the ID/EXE register contents.
- flush  input  1  replace the next EXE entry with a bubble.
- d_valid  input  1  ID-stage instruction valid.
- d_inst  input  32  ID-stage instruction word.
- d_qa  input  DATA_W  rs register value (already forwarded).
- d_qb  input  DATA_W  rt register value (already forwarded).
- e_valid  output  1  EXE-stage entry valid.
- ealuc  output  4  ALU control to EXE ALU.
- eqa  output  DATA_W  ALU operand A.
- b  output  DATA_W  ALU operand B (d_qb or extended immediate).
- e_qb  output  DATA_W  registered rt value (store data / branch compare).
- e_aluimm  output  1  1 when b came from the immediate.
- e_illegal  output  1  registered flag: unsupported instruction was dropped.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high (rst). While rst=1, all outputs are 0 (ealuc=4'b0000), regardless of clk.
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB. No other codes are ever produced.
- Decode (op = d_inst[31:26], funct = d_inst[5:0]):
  - R-type op 000000: funct 100000→0010; 100010→0110; 100100→0000; 100101→0001; b=d_qb, aluimm=0.
  - addi 001000 → 0010, sign-extended imm.
  - andi 001100 → 0000, zero-extended imm.
  - ori 001101 → 0001, zero-extended imm.
  - lw 100011 and sw 101011 → 0010, sign-extended imm.
  - beq 000100 → 0110, b=d_qb, aluimm=0.
  - Any other op, or R-type with any other funct, is illegal.
- Update priority at each rising edge: rst (async) > flush > stall > load.
  - flush=1: load a bubble (all outputs 0). flush wins over a simultaneous stall.
  - stall=1 and flush=0: every output holds its value, including e_illegal.
  - Otherwise, with d_valid=1 and a legal instruction: e_valid=1, ealuc/eqa/b/e_qb/e_aluimm take the decoded values, e_illegal=0.
  - d_valid=1 and illegal: load a bubble with e_illegal=1. The flag lasts exactly one cycle unless stalled.
  - d_valid=0: load a bubble, e_illegal=0.
- Latency: exactly 1 cycle from ID inputs to EXE outputs; no combinational path from inputs to outputs.
- Extension:
  - Sign extension replicates imm[IMM_W-1] into bits DATA_W-1..IMM_W.
  - Zero extension fills those bits with 0.
- Reset mid-operation: registered state is cleared immediately. The first edge after rst deasserts follows the normal priority rules.
- Stall applied indefinitely: outputs are stable for every cycle of the stall.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU code constants: ALUC_AND=4'b0000, ALUC_OR=4'b0001, ALUC_ADD=4'b0010, ALUC_SUB=4'b0110.
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ.
  - Funct constants: F_ADD, F_SUB, F_AND, F_OR.
  - DATA_W default.
- One combinational sub-module, alu_ctrl_decode: inputs op and funct; outputs aluc, aluimm, sext, illegal.
- The top level holds the extension mux and the ID/EXE register.

Test Plan:
1. Reset: assert rst mid-cycle with e_valid=1 → all outputs 0 immediately, before the next edge.
2. R-type add: d_inst=0x00221820, d_qa=5, d_qb=7, d_valid=1 → next cycle e_valid=1, ealuc=0010, eqa=5, b=7, e_aluimm=0.
3. Extension:
   - addi with imm=0xFFFC, d_qa=10 → ealuc=0010, b=0xFFFFFFFC.
   - ori with imm=0x8001 → ealuc=0001, b=0x00008001, e_aluimm=1.
4. Stall and flush:
   - Load sub (funct 100010), then stall=1 for 3 cycles while d_inst changes to andi → outputs hold ealuc=0110 throughout.
   - Then stall=1 and flush=1 together → bubble (e_valid=0, ealuc=0000).
5. Illegal: op=111111 with d_valid=1 → next cycle e_valid=0, e_illegal=1; following cycle, with a legal instruction, e_illegal=0.
6. beq and lw back-to-back:
   - beq, d_qa=3, d_qb=3 → ealuc=0110, b=3.
   - lw with imm=0x0010 → ealuc=0010, b=0x10, e_aluimm=1.
   - d_valid=0 next → e_valid=0, e_illegal=0.
